// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared definitions for the multi-cycle sequencer:
//               - mc_state_t : sequencer state encoding (3 bits)
//               - c_opc_*    : RV32/RV64 base opcode constants (ir[6:0])
//               - pc_aligned : helper for the WB next-PC alignment check
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } mc_state_t;

   localparam logic [6:0] c_opc_load      = 7'b0000011;
   localparam logic [6:0] c_opc_misc_mem  = 7'b0001111;
   localparam logic [6:0] c_opc_op_imm    = 7'b0010011;
   localparam logic [6:0] c_opc_auipc     = 7'b0010111;
   localparam logic [6:0] c_opc_op_imm_32 = 7'b0011011;
   localparam logic [6:0] c_opc_store     = 7'b0100011;
   localparam logic [6:0] c_opc_op        = 7'b0110011;
   localparam logic [6:0] c_opc_lui       = 7'b0110111;
   localparam logic [6:0] c_opc_op_32     = 7'b0111011;
   localparam logic [6:0] c_opc_branch    = 7'b1100011;
   localparam logic [6:0] c_opc_jalr      = 7'b1100111;
   localparam logic [6:0] c_opc_jal       = 7'b1101111;
   localparam logic [6:0] c_opc_system    = 7'b1110011;

   // Instructions are 32-bit and word aligned; any other next-PC is a fault.
   function automatic logic pc_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_opclass.sv
`default_nettype none
// ============================================================================
// Module      : mc_opclass
// Description : Purely combinational opcode classifier for the sequencer.
//               Every recognised base opcode ends in 2'b11, so an instruction
//               with ir[1:0] != 2'b11 never matches and is reported illegal.
// Ports       : i_opcode    [6:0] in  - ir[6:0] of the current instruction
//               o_is_mem          out - load or store (needs a MEM phase)
//               o_is_store        out - store (dmem_we during MEM)
//               o_writes_rd       out - instruction writes the register file
//               o_is_sys          out - SYSTEM opcode (orderly halt)
//               o_legal           out - opcode is recognised
// Revision    : 1.0 - initial release
// ============================================================================
module mc_opclass
   import mc_pkg::*;
(
   input  logic [6:0] i_opcode,
   output logic       o_is_mem,
   output logic       o_is_store,
   output logic       o_writes_rd,
   output logic       o_is_sys,
   output logic       o_legal
);

   always_comb begin
      o_is_mem    = 1'b0;
      o_is_store  = 1'b0;
      o_writes_rd = 1'b0;
      o_is_sys    = 1'b0;
      o_legal     = 1'b0;
      case (i_opcode)
         c_opc_load: begin
            o_legal     = 1'b1;
            o_is_mem    = 1'b1;
            o_writes_rd = 1'b1;
         end
         c_opc_store: begin
            o_legal    = 1'b1;
            o_is_mem   = 1'b1;
            o_is_store = 1'b1;
         end
         c_opc_op, c_opc_op_imm, c_opc_op_32, c_opc_op_imm_32,
         c_opc_lui, c_opc_auipc, c_opc_jal, c_opc_jalr: begin
            o_legal     = 1'b1;
            o_writes_rd = 1'b1;
         end
         c_opc_branch, c_opc_misc_mem: begin
            o_legal = 1'b1;
         end
         c_opc_system: begin
            o_legal  = 1'b1;
            o_is_sys = 1'b1;
         end
         default: begin
            o_legal = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mc_sequencer
// Description : Multi-cycle instruction sequencer. Walks each instruction
//               through FETCH -> DECODE -> EXEC -> [MEM] -> WB, drives the
//               instruction/data memory handshakes and the register-file
//               write strobe, and halts (sticky until reset) on SYSTEM,
//               illegal opcodes, misaligned next-PC or a memory timeout.
// Parameters  : XLEN     - PC / datapath width (32 or 64)
//               RESET_PC - PC value loaded by reset
//               MAX_WAIT - request cycles without ack before a timeout halt
// Ports       : clk, rst_n (async, active-low)
//               imem_req/imem_ack/imem_addr/imem_rdata - fetch handshake
//               dmem_req/dmem_we/dmem_ack              - data handshake
//               pc_next  - next PC from the datapath, consumed in WB
//               pc, ir   - registered PC and instruction
//               reg_we   - register-file write strobe (WB only)
//               state, halted, err - sequencer status
//               cycle_cnt, instret_cnt - present only with
//                 MC_SEQUENCER_PERF_EN defined (performance counters)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_sequencer
   import mc_pkg::*;
#(
   parameter int               XLEN     = 64,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter int               MAX_WAIT = 255
) (
`ifdef MC_SEQUENCER_PERF_EN
   output logic [63:0]     cycle_cnt,
   output logic [63:0]     instret_cnt,
`endif
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   input  logic            imem_ack,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] pc_next,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     ir,
   output logic            reg_we,
   output logic [2:0]      state,
   output logic            halted,
   output logic            err
);

   // The wait counter runs 0 .. MAX_WAIT-1 across consecutive request cycles.
   localparam int                  c_wait_w    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MAX_WAIT - 1);
   localparam logic [c_wait_w-1:0] c_wait_one  = c_wait_w'(1);

   mc_state_t         r_state;
   logic [XLEN-1:0]   r_pc;
   logic [31:0]       r_ir;
   logic              r_halted;
   logic              r_err;
   logic [c_wait_w-1:0] r_wait;

   logic w_is_mem;
   logic w_is_store;
   logic w_writes_rd;
   logic w_is_sys;
   logic w_legal;
   logic w_pc_ok;

   mc_opclass u_opclass (
      .i_opcode    (r_ir[6:0]),
      .o_is_mem    (w_is_mem),
      .o_is_store  (w_is_store),
      .o_writes_rd (w_writes_rd),
      .o_is_sys    (w_is_sys),
      .o_legal     (w_legal)
   );

   assign w_pc_ok = pc_aligned(pc_next[1:0]);

   // ------------------------------------------------------------------------
   // Sequencer FSM. Acks are only examined in the state that owns the
   // matching request, so stray acks elsewhere have no effect.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_FETCH;
         r_pc     <= RESET_PC;
         r_ir     <= 32'h0;
         r_halted <= 1'b0;
         r_err    <= 1'b0;
         r_wait   <= '0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (imem_ack) begin
                  r_ir    <= imem_rdata;
                  r_wait  <= '0;
                  r_state <= ST_DECODE;
               end else if (r_wait == c_wait_last) begin
                  r_wait   <= '0;
                  r_halted <= 1'b1;
                  r_err    <= 1'b1;
                  r_state  <= ST_HALT;
               end else begin
                  r_wait <= r_wait + c_wait_one;
               end
            end

            ST_DECODE: begin
               if (w_is_sys) begin
                  r_halted <= 1'b1;
                  r_err    <= 1'b0;
                  r_state  <= ST_HALT;
               end else if (!w_legal) begin
                  r_halted <= 1'b1;
                  r_err    <= 1'b1;
                  r_state  <= ST_HALT;
               end else begin
                  r_state <= ST_EXEC;
               end
            end

            ST_EXEC: begin
               r_state <= w_is_mem ? ST_MEM : ST_WB;
            end

            ST_MEM: begin
               if (dmem_ack) begin
                  r_wait  <= '0;
                  r_state <= ST_WB;
               end else if (r_wait == c_wait_last) begin
                  r_wait   <= '0;
                  r_halted <= 1'b1;
                  r_err    <= 1'b1;
                  r_state  <= ST_HALT;
               end else begin
                  r_wait <= r_wait + c_wait_one;
               end
            end

            ST_WB: begin
               // A misaligned next PC aborts the instruction: PC is kept
               // so the faulting instruction address remains visible.
               if (!w_pc_ok) begin
                  r_halted <= 1'b1;
                  r_err    <= 1'b1;
                  r_state  <= ST_HALT;
               end else begin
                  r_pc    <= pc_next;
                  r_state <= ST_FETCH;
               end
            end

            ST_HALT: begin
               r_state <= ST_HALT;
            end

            default: begin
               // Unreachable encodings are treated as a fault.
               r_halted <= 1'b1;
               r_err    <= 1'b1;
               r_state  <= ST_HALT;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Strobes are decoded straight from the state register. imem_req is also
   // gated by rst_n so it is low throughout reset yet high in the very first
   // cycle after release. reg_we needs pc_next, which is only valid in WB.
   // ------------------------------------------------------------------------
   assign imem_req  = rst_n & (r_state == ST_FETCH);
   assign imem_addr = r_pc;
   assign dmem_req  = (r_state == ST_MEM);
   assign dmem_we   = (r_state == ST_MEM) & w_is_store;
   assign reg_we    = (r_state == ST_WB) & w_writes_rd & w_pc_ok;

   assign pc     = r_pc;
   assign ir     = r_ir;
   assign state  = r_state;
   assign halted = r_halted;
   assign err    = r_err;

`ifdef MC_SEQUENCER_PERF_EN
   logic [63:0] r_cycle_cnt;
   logic [63:0] r_instret_cnt;

   // Retirement is a WB that advances to FETCH; a faulting WB does not count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_cnt   <= 64'd0;
         r_instret_cnt <= 64'd0;
      end else begin
         if (r_state != ST_HALT) begin
            r_cycle_cnt <= r_cycle_cnt + 64'd1;
         end
         if ((r_state == ST_WB) && w_pc_ok) begin
            r_instret_cnt <= r_instret_cnt + 64'd1;
         end
      end
   end

   assign cycle_cnt   = r_cycle_cnt;
   assign instret_cnt = r_instret_cnt;
`endif

endmodule
`default_nettype wire
